uart_cmd_master: RTL and testbench
==================================

# uart_cmd_master

Host-side command initiator for the UART register/ALU command protocol served by the system controller. It accepts one command on a parallel valid/ready port and serializes it into frame bytes for a UART transmitter. It then collects the response bytes from a UART receiver and returns a single response word with status flags. It drives the protocol's other end in bench-level loopback and in host-bridge builds.

## Interface
- `width`, 8, data byte width; the response word is `2*width`.
- `TIMEOUT`, 1024, cycles allowed in response wait before abort; must be at least 2.

- `CLK`  in  1  single clock; all logic is rising-edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_type`  in  2  command type: 0=WR, 1=RD, 2=ALU_OP (with operands), 3=ALU_NOP.
- `cmd_addr`  in  4  register-file address (WR, RD).
- `cmd_data`  in  width  write data (WR).
- `cmd_opA`, `cmd_opB`  in  width  ALU operands (ALU_OP).
- `cmd_fun`  in  4  ALU function (ALU_OP, ALU_NOP).
- `tx_byte`  out  width  byte to UART TX.
- `tx_valid`  out  1  byte offered; accepted when `tx_valid & !tx_busy`.
- `tx_busy`  in  1  UART TX busy.
- `rx_byte`  in  width  received byte.
- `rx_valid`  in  1  one-cycle pulse; `rx_byte` is valid in that cycle.
- `rx_error`  in  1  parity or stop error, qualified by `rx_valid`.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_data`  out  2*width  response word.
- `rsp_timeout`  out  1  status flag, valid with `rsp_valid`.
- `rsp_error`  out  1  status flag, valid with `rsp_valid`.
- `busy`  out  1  high whenever the block is not in IDLE.

## Operation
- Frames sent, in byte order:
  - WR: 0xAA, `{4'b0,addr}`, data. No response.
  - RD: 0xBB, `{4'b0,addr}`. Response is 1 byte.
  - ALU_OP: 0xCC, opA, opB, `{4'b0,fun}`. Response is 2 bytes, LSB first.
  - ALU_NOP: 0xDD, `{4'b0,fun}`. Response is 2 bytes, LSB first.
- All `cmd_*` fields are registered on acceptance. Later input changes have no effect on the command in flight.
- FSM states: IDLE, SEND, WAIT_RSP, DONE.
  - IDLE: `cmd_ready=1`. On acceptance, go to SEND with byte index 0.
  - SEND: `tx_valid=1`, and `tx_byte` is the frame byte at the current index. Both hold until accepted; then the index increments.
  - SEND after the last byte is accepted: WR goes to DONE; all others go to WAIT_RSP with the timeout counter and response byte count cleared.
  - WAIT_RSP, on `rx_valid & !rx_error`: capture byte 0 into `rsp_data[7:0]` and byte 1 into `rsp_data[15:8]`. After the expected count (1 or 2), go to DONE.
  - WAIT_RSP, on `rx_valid & rx_error`: go to DONE with `rsp_error=1`. Bytes already captured are kept.
  - WAIT_RSP timeout: the counter increments every cycle. When it reaches TIMEOUT-1 with no completing byte, go to DONE with `rsp_timeout=1` and `rsp_data=0`.
  - DONE: `rsp_valid=1` for exactly one cycle, then IDLE.
- WR completes with `rsp_data=0` and both flags 0.
- RD leaves `rsp_data[15:8]=0`.
- `rx_valid` outside WAIT_RSP is ignored and dropped.
- Flags and `rsp_data` hold their values until the next command is accepted, where they clear.

## Timing
- Reset values: `cmd_ready=1`, and `tx_valid`, `tx_byte`, `rsp_valid`, `rsp_data`, `rsp_timeout`, `rsp_error`, `busy` all 0. FSM returns to IDLE.
- Reset mid-frame aborts immediately. `tx_valid` drops asynchronously and no `rsp_valid` is produced.
- Acceptance to first `tx_valid`: exactly 1 cycle.
- Consecutive bytes:
  - The next byte is offered in the cycle after acceptance.
  - With `tx_busy=0` throughout, a frame of N bytes needs N consecutive `tx_valid` cycles.
- Last response byte (`rx_valid`) to `rsp_valid`: 1 cycle.
- WR: `rsp_valid` follows the acceptance of the last byte by 1 cycle.
- Timeout:
  - Counting starts the cycle after entry to WAIT_RSP.
  - `rsp_valid` comes TIMEOUT+1 cycles after entry.
  - An `rx_valid` that completes the response in the same cycle as the timeout takes priority; the response is normal.
- `cmd_ready` returns to 1 the cycle after `rsp_valid`. No back-to-back acceptance occurs during DONE.

## Test plan
- WR, addr=3, data=0x5A, `tx_busy=0`:
  - `tx_byte` sequence is 0xAA, 0x03, 0x5A on 3 consecutive cycles.
  - `rsp_valid` with `rsp_data=0x0000` and both flags 0.
- RD, addr=2, with `tx_busy` high for 10 cycles after each byte:
  - Each byte is held stable until accepted.
  - Inject `rx_byte=0x81`: `rsp_data=0x0081` one cycle later.
- ALU_OP, opA=0x12, opB=0x34, fun=0:
  - Frame is 0xCC, 0x12, 0x34, 0x00.
  - Respond 0x46 then 0x00: `rsp_data=0x0046`.
- ALU_NOP, fun=2, TIMEOUT=16, no response:
  - `rsp_valid` with `rsp_timeout=1` and `rsp_data=0` exactly 17 cycles after WAIT_RSP entry.
- ALU_NOP with the first response byte carrying `rx_error=1`: `rsp_error=1`. Also drive a stray `rx_valid` during SEND: it is ignored.
- Assert `Reset` during byte 2 of ALU_OP:
  - All outputs return to reset values immediately.
  - The next WR executes cleanly.

Source files
------------

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: serializes register/ALU commands into UART frame
// bytes and collects the response word with timeout/error status.
module uart_cmd_master #(
  parameter int width   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [3:0]         cmd_addr,
  input  logic [width-1:0]   cmd_data,
  input  logic [width-1:0]   cmd_opA,
  input  logic [width-1:0]   cmd_opB,
  input  logic [3:0]         cmd_fun,
  output logic [width-1:0]   tx_byte,
  output logic               tx_valid,
  input  logic               tx_busy,
  input  logic [width-1:0]   rx_byte,
  input  logic               rx_valid,
  input  logic               rx_error,
  output logic               rsp_valid,
  output logic [2*width-1:0] rsp_data,
  output logic               rsp_timeout,
  output logic               rsp_error,
  output logic               busy
);

  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] C_WR  = 2'd0;
  localparam logic [1:0] C_RD  = 2'd1;
  localparam logic [1:0] C_ALU = 2'd2;
  localparam logic [1:0] C_NOP = 2'd3;

  localparam logic [7:0] H_WR  = 8'hAA;
  localparam logic [7:0] H_RD  = 8'hBB;
  localparam logic [7:0] H_ALU = 8'hCC;
  localparam logic [7:0] H_NOP = 8'hDD;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         typ_q, typ_d;
  logic [3:0]         addr_q, addr_d;
  logic [width-1:0]   data_q, data_d;
  logic [width-1:0]   opa_q, opa_d;
  logic [width-1:0]   opb_q, opb_d;
  logic [3:0]         fun_q, fun_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               run_q, run_d;
  logic               rcnt_q, rcnt_d;
  logic [2*width-1:0] rdat_q, rdat_d;
  logic               tflag_q, tflag_d;
  logic               eflag_q, eflag_d;

  logic               is_wr, is_rd, is_alu, is_nop;
  logic [1:0]         last_idx;
  logic [width-1:0]   frame_b;
  logic               rx_last;
  logic               tmo_hit;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      typ_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      fun_q   <= '0;
      tmo_q   <= '0;
      run_q   <= 1'b0;
      rcnt_q  <= 1'b0;
      rdat_q  <= '0;
      tflag_q <= 1'b0;
      eflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      typ_q   <= typ_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      fun_q   <= fun_d;
      tmo_q   <= tmo_d;
      run_q   <= run_d;
      rcnt_q  <= rcnt_d;
      rdat_q  <= rdat_d;
      tflag_q <= tflag_d;
      eflag_q <= eflag_d;
    end
  end

  assign is_wr  = (typ_q == C_WR);
  assign is_rd  = (typ_q == C_RD);
  assign is_alu = (typ_q == C_ALU);
  assign is_nop = (typ_q == C_NOP);

  always_comb begin
    last_idx = 2'd1;
    frame_b  = '0;
    unique case (1'b1)
      is_wr: begin
        last_idx = 2'd2;
        case (idx_q)
          2'd0:    frame_b = width'(H_WR);
          2'd1:    frame_b = width'(addr_q);
          default: frame_b = data_q;
        endcase
      end
      is_rd: begin
        last_idx = 2'd1;
        frame_b  = (idx_q == 2'd0) ? width'(H_RD)
                                   : width'(addr_q);
      end
      is_alu: begin
        last_idx = 2'd3;
        case (idx_q)
          2'd0:    frame_b = width'(H_ALU);
          2'd1:    frame_b = opa_q;
          2'd2:    frame_b = opb_q;
          default: frame_b = width'(fun_q);
        endcase
      end
      is_nop: begin
        last_idx = 2'd1;
        frame_b  = (idx_q == 2'd0) ? width'(H_NOP)
                                   : width'(fun_q);
      end
      default: begin
        last_idx = 2'd1;
        frame_b  = '0;
      end
    endcase
  end

  // RD needs one response byte, both ALU forms need two
  assign rx_last = is_rd ? 1'b1 : rcnt_q;
  assign tmo_hit = run_q && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    typ_d   = typ_q;
    addr_d  = addr_q;
    data_d  = data_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    fun_d   = fun_q;
    tmo_d   = tmo_q;
    run_d   = run_q;
    rcnt_d  = rcnt_q;
    rdat_d  = rdat_q;
    tflag_d = tflag_q;
    eflag_d = eflag_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          typ_d   = cmd_type;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          opa_d   = cmd_opA;
          opb_d   = cmd_opB;
          fun_d   = cmd_fun;
          rdat_d  = '0;
          tflag_d = 1'b0;
          eflag_d = 1'b0;
          idx_d   = 2'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          if (idx_q == last_idx) begin
            if (is_wr) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
              tmo_d   = '0;
              run_d   = 1'b0;
              rcnt_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WAIT: begin
        // entry cycle does not count; timer runs from the next one
        run_d = 1'b1;
        if (run_q) tmo_d = tmo_q + TW'(1);
        if (rx_valid && rx_error) begin
          eflag_d = 1'b1;
          state_d = S_DONE;
        end else if (rx_valid && rx_last) begin
          if (rcnt_q) rdat_d[2*width-1:width] = rx_byte;
          else        rdat_d[width-1:0]       = rx_byte;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          tflag_d = 1'b1;
          rdat_d  = '0;
          state_d = S_DONE;
        end else if (rx_valid) begin
          rdat_d[width-1:0] = rx_byte;
          rcnt_d            = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tx_valid    = (state_q == S_SEND);
  assign tx_byte     = tx_valid ? frame_b : '0;
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_data    = rdat_q;
  assign rsp_timeout = tflag_q;
  assign rsp_error   = eflag_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: directed vector table plus hand sequences for
// timeout, timeout/response race and mid-frame reset.
module tb_uart_cmd_master;

  localparam int W   = 8;
  localparam int TMO = 16;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_type;
  logic [3:0]   cmd_addr;
  logic [W-1:0] cmd_data;
  logic [W-1:0] cmd_opA;
  logic [W-1:0] cmd_opB;
  logic [3:0]   cmd_fun;
  logic [W-1:0] tx_byte;
  logic         tx_valid;
  logic         tx_busy;
  logic [W-1:0] rx_byte;
  logic         rx_valid;
  logic         rx_error;
  logic         rsp_valid;
  logic [2*W-1:0] rsp_data;
  logic         rsp_timeout;
  logic         rsp_error;
  logic         busy;

  always #5 CLK = ~CLK;

  uart_cmd_master #(.width(W), .TIMEOUT(TMO)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_type(cmd_type),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .cmd_opA(cmd_opA),
    .cmd_opB(cmd_opB),
    .cmd_fun(cmd_fun),
    .tx_byte(tx_byte),
    .tx_valid(tx_valid),
    .tx_busy(tx_busy),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_error(rx_error),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .rsp_error(rsp_error),
    .busy(busy)
  );

  typedef struct {
    logic [1:0]  ctype;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [3:0]  fun;
    int          nb;
    logic [31:0] frame;
    int          gap;
    bit          stray;
    int          nrx;
    logic [15:0] rxb;
    int          erri;
    logic [15:0] exp_data;
    bit          exp_err;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t mk(
    input logic [1:0] t, input logic [3:0] a,
    input logic [7:0] d, input logic [7:0] oa,
    input logic [7:0] ob, input logic [3:0] f,
    input int nb, input logic [31:0] fr,
    input int gap, input bit st,
    input int nrx, input logic [15:0] rb,
    input int ei, input logic [15:0] ed,
    input bit ee);
    vec_t v;
    v.ctype = t;   v.addr = a;   v.data = d;
    v.opa = oa;    v.opb = ob;   v.fun = f;
    v.nb = nb;     v.frame = fr; v.gap = gap;
    v.stray = st;  v.nrx = nrx;  v.rxb = rb;
    v.erri = ei;   v.exp_data = ed;
    v.exp_err = ee;
    return v;
  endfunction

  task automatic send_cmd(input vec_t v);
    logic [7:0] eb;
    cmd_type  = v.ctype;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    cmd_opA   = v.opa;
    cmd_opB   = v.opb;
    cmd_fun   = v.fun;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    tick();
    cmd_valid = 1'b0;
    cmd_type  = ~v.ctype;
    cmd_addr  = ~v.addr;
    cmd_data  = ~v.data;
    cmd_opA   = ~v.opa;
    cmd_opB   = ~v.opb;
    cmd_fun   = ~v.fun;
    chk("rsp_clr_data", 32'(rsp_data), 32'd0);
    chk("rsp_clr_flags",
        32'({rsp_error, rsp_timeout}), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
    chk("cmd_ready_run", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < v.nb; i++) begin
      eb = v.frame[8*i +: 8];
      if (v.stray && i == 0) begin
        rx_byte  = 8'h99;
        rx_error = 1'b0;
        rx_valid = 1'b1;
      end
      if (v.gap > 0) begin
        tx_busy = 1'b1;
        for (int g = 0; g < v.gap; g++) begin
          chk("tx_hold_valid", 32'(tx_valid), 32'd1);
          chk("tx_hold_byte", 32'(tx_byte), 32'(eb));
          tick();
          rx_valid = 1'b0;
        end
        tx_busy = 1'b0;
      end
      chk("tx_valid", 32'(tx_valid), 32'd1);
      chk("tx_byte", 32'(tx_byte), 32'(eb));
      tick();
      rx_valid = 1'b0;
    end
  endtask

  task automatic finish_rsp(input vec_t v);
    if (v.nrx > 0) begin
      tick();
      tick();
      for (int i = 0; i < v.nrx; i++) begin
        rx_byte  = v.rxb[8*i +: 8];
        rx_error = (i == v.erri);
        rx_valid = 1'b1;
        chk("rsp_pending", 32'(rsp_valid), 32'd0);
        tick();
        rx_valid = 1'b0;
        rx_error = 1'b0;
        if (i == v.erri) break;
      end
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(v.exp_data));
    chk("rsp_error", 32'(rsp_error), 32'(v.exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'd0);
    tick();
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("ready_back", 32'(cmd_ready), 32'd1);
    chk("rsp_hold", 32'(rsp_data), 32'(v.exp_data));
    chk("err_hold", 32'(rsp_error), 32'(v.exp_err));
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    tbl[0] = mk(2'd0, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0,
                3, 32'h005A03AA, 0, 1'b0,
                0, 16'h0000, -1, 16'h0000, 1'b0);
    tbl[1] = mk(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0,
                2, 32'h000002BB, 10, 1'b0,
                1, 16'h0081, -1, 16'h0081, 1'b0);
    tbl[2] = mk(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0,
                4, 32'h003412CC, 0, 1'b0,
                2, 16'h0046, -1, 16'h0046, 1'b0);
    tbl[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2,
                2, 32'h000002DD, 0, 1'b1,
                1, 16'h005E, 0, 16'h0000, 1'b1);
    tbl[4] = mk(2'd2, 4'h0, 8'h00, 8'hA5, 8'h3C, 4'hF,
                4, 32'h0F3CA5CC, 0, 1'b0,
                2, 16'h7711, 1, 16'h0011, 1'b1);
    tbl[5] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7,
                2, 32'h000007DD, 0, 1'b0,
                2, 16'hBEEF, -1, 16'hBEEF, 1'b0);
    tbl[6] = mk(2'd1, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0,
                2, 32'h00000ABB, 2, 1'b0,
                1, 16'h00C3, -1, 16'h00C3, 1'b0);
    tbl[7] = mk(2'd0, 4'hF, 8'hFF, 8'h00, 8'h00, 4'h0,
                3, 32'h00FF0FAA, 0, 1'b0,
                0, 16'h0000, -1, 16'h0000, 1'b0);

    Reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = '0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_opA   = '0;
    cmd_opB   = '0;
    cmd_fun   = '0;
    tx_busy   = 1'b0;
    rx_byte   = '0;
    rx_valid  = 1'b0;
    rx_error  = 1'b0;
    #1 Reset = 1'b1;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_flags", 32'({rsp_error, rsp_timeout}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge CLK);
    #1 Reset = 1'b0;
    tick();

    for (int n = 0; n < 8; n++) begin
      send_cmd(tbl[n]);
      finish_rsp(tbl[n]);
      tick();
    end

    // timeout with a partial first byte: data must still read zero
    v = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2,
           2, 32'h000002DD, 0, 1'b0,
           0, 16'h0000, -1, 16'h0000, 1'b0);
    send_cmd(v);
    for (int k = 0; k <= TMO + 1; k++) begin
      if (k == 5) begin
        rx_byte  = 8'h55;
        rx_valid = 1'b1;
      end
      chk("tmo_wait", 32'(rsp_valid), 32'(k == TMO + 1));
      if (k < TMO + 1) begin
        tick();
        rx_valid = 1'b0;
      end
    end
    chk("tmo_flag", 32'(rsp_timeout), 32'd1);
    chk("tmo_data", 32'(rsp_data), 32'd0);
    chk("tmo_err", 32'(rsp_error), 32'd0);
    tick();
    chk("tmo_pulse", 32'(rsp_valid), 32'd0);
    chk("tmo_hold", 32'(rsp_timeout), 32'd1);
    tick();

    // completing byte lands on the timeout cycle
    v = mk(2'd1, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0,
           2, 32'h000001BB, 0, 1'b0,
           0, 16'h0000, -1, 16'h0000, 1'b0);
    send_cmd(v);
    for (int k = 0; k < TMO; k++) begin
      chk("race_wait", 32'(rsp_valid), 32'd0);
      tick();
    end
    rx_byte  = 8'h3C;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("race_valid", 32'(rsp_valid), 32'd1);
    chk("race_tmo", 32'(rsp_timeout), 32'd0);
    chk("race_data", 32'(rsp_data), 32'h003C);
    tick();
    tick();

    // reset while byte 2 of an ALU_OP frame is on the wire
    cmd_type  = 2'd2;
    cmd_opA   = 8'h12;
    cmd_opB   = 8'h34;
    cmd_fun   = 4'h0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rst_mid_byte", 32'(tx_byte), 32'h34);
    #2 Reset = 1'b1;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_tx_byte", 32'(tx_byte), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_rsp", 32'(rsp_valid), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    send_cmd(tbl[0]);
    finish_rsp(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
